// File: rtl/inv_cipher_pkg.sv
// inv_cipher_pkg: widths, round classification and GF(2^8) / inverse S-box helpers
// shared by the iterative AES decryption core.
package inv_cipher_pkg;
  localparam int BLK_S          = 128;
  localparam int Nb             = 4;
  localparam int WORD_S         = 32;
  localparam int BYTE_S         = 8;
  localparam int ROUND_KEY_BITS = 128;

  typedef logic [BLK_S-1:0]  aes_block_t;
  typedef logic [WORD_S-1:0] aes_word_t;
  typedef logic [BYTE_S-1:0] aes_byte_t;

  typedef enum logic [1:0] {
    RK_INIT,
    RK_MID,
    RK_FINAL
  } round_kind_e;

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Word 0 and byte 0 sit at the most significant end, matching the encryption core.
  function automatic aes_word_t aes_word(aes_block_t blk, int idx);
    return blk[BLK_S-1-WORD_S*idx -: WORD_S];
  endfunction

  function automatic aes_byte_t aes_byte(aes_word_t w, int idx);
    return w[WORD_S-1-BYTE_S*idx -: BYTE_S];
  endfunction

  function automatic aes_byte_t get_inv_sbox(aes_byte_t b);
    return INV_SBOX[b];
  endfunction

  function automatic aes_byte_t xtime(aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gm9(aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic aes_byte_t gm11(aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic aes_byte_t gm13(aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic aes_byte_t gm14(aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic aes_word_t inv_mix_word(aes_word_t w);
    aes_byte_t a0, a1, a2, a3;
    a0 = aes_byte(w, 0);
    a1 = aes_byte(w, 1);
    a2 = aes_byte(w, 2);
    a3 = aes_byte(w, 3);
    return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3),
            gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3),
            gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3)};
  endfunction
endpackage

// File: rtl/inv_cipher_if.sv
// inv_cipher_if: block input/output and round-key request/return signals of the
// decryption core; master is the driver plus key store, slave is the core.
interface inv_cipher_if;
  import inv_cipher_pkg::*;

  logic                      en;
  aes_block_t                ciphertext;
  logic [Nb-1:0]             rounds_total;
  logic [ROUND_KEY_BITS-1:0] key;
  aes_block_t                plaintext;
  logic [Nb-1:0]             round_key_no;
  logic                      en_o;

  modport master (
    output en, ciphertext, rounds_total, key,
    input  plaintext, round_key_no, en_o
  );

  modport slave (
    input  en, ciphertext, rounds_total, key,
    output plaintext, round_key_no, en_o
  );
endinterface

// File: rtl/inv_cipher_inv_round.sv
// inv_round: one combinational AES decryption round - InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module inv_round
  import inv_cipher_pkg::*;
(
  input  aes_block_t state_i,
  input  aes_block_t key_i,
  input  logic       last_i,
  output aes_block_t state_o
);
  aes_block_t subbed;
  aes_block_t added;
  aes_block_t mixed;

  // Row r rotates right by r bytes: column c row r is taken from column (c - r) mod 4.
  always_comb begin
    subbed = '0;
    for (int c = 0; c < Nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        subbed[BLK_S-1-WORD_S*c-BYTE_S*r -: BYTE_S] =
          get_inv_sbox(aes_byte(aes_word(state_i, (c + Nb - r) % Nb), r));
      end
    end
  end

  assign added = subbed ^ key_i;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < Nb; c++) begin
      mixed[BLK_S-1-WORD_S*c -: WORD_S] = inv_mix_word(aes_word(added, c));
    end
  end

  assign state_o = last_i ? added : mixed;
endmodule

// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES-128/192/256 decryption, one round per clock; requests round
// keys Nr..0 from an external store that answers one cycle later.
module inv_cipher
  import inv_cipher_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  inv_cipher_if.slave  bus
);
  logic          key_req_q, key_req_d;
  logic          round_en_q;
  logic [Nb-1:0] round_no_q, round_no_d;
  logic [Nb-1:0] round_key_no_q, round_key_no_d;
  aes_block_t    state_q, state_d;
  logic          en_o_q;
  round_kind_e   kind;
  aes_block_t    round_out;
  logic          idle;

  assign idle = !key_req_q && !round_en_q;

  always_comb begin
    kind = RK_MID;
    if (round_no_q == '0) begin
      kind = RK_INIT;
    end else if (round_no_q == bus.rounds_total) begin
      kind = RK_FINAL;
    end
  end

  inv_round u_inv_round (
    .state_i (state_q),
    .key_i   (bus.key),
    .last_i  (kind == RK_FINAL),
    .state_o (round_out)
  );

  // Key requests run Nr down to 0; index 0 is held once the request window closes.
  always_comb begin
    key_req_d      = key_req_q;
    round_key_no_d = round_key_no_q;
    if (idle && bus.en) begin
      key_req_d      = 1'b1;
      round_key_no_d = bus.rounds_total;
    end else if (key_req_q) begin
      if (round_key_no_q == '0) begin
        key_req_d = 1'b0;
      end else begin
        round_key_no_d = round_key_no_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    round_no_d = round_no_q;
    if (round_en_q) begin
      if (kind == RK_INIT) begin
        state_d = bus.ciphertext ^ bus.key;
      end else begin
        state_d = round_out;
      end
      round_no_d = (kind == RK_FINAL) ? '0 : round_no_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_req_q      <= 1'b0;
      round_en_q     <= 1'b0;
      round_no_q     <= '0;
      round_key_no_q <= '0;
      state_q        <= '0;
      en_o_q         <= 1'b0;
    end else begin
      key_req_q      <= key_req_d;
      round_en_q     <= key_req_q;
      round_no_q     <= round_no_d;
      round_key_no_q <= round_key_no_d;
      state_q        <= state_d;
      en_o_q         <= round_en_q && (round_no_q == bus.rounds_total);
    end
  end

  assign bus.plaintext    = state_q;
  assign bus.round_key_no = round_key_no_q;
  assign bus.en_o         = en_o_q;
endmodule

// File: doc/inv_cipher.md
# inv_cipher

Iterative AES inverse cipher (decryption) core: one round per clock, one 128-bit block at a time, for AES-128/192/256 (rounds_total = 10/12/14). It is the decrypt-side counterpart of the encryption round engine. It sits behind the key-expansion store and requests round keys in descending order via `round_key_no`. Round keys return one cycle after each request.

## Interface
Parameters: none. Widths come from `aes.vh`: `BLK_S`=128, `Nb`=4, `ROUND_KEY_BITS`=128.
- clk  in  1  clock; reset synchronous, active-high; all logic on posedge clk
- reset  in  1  synchronous, active-high
- en  in  1  start pulse; accepted only when idle
- ciphertext  in  BLK_S  input block; held stable from en until en_o
- rounds_total  in  Nb  Nr (10/12/14); held stable from en until en_o
- key  in  ROUND_KEY_BITS  round key addressed by `round_key_no` in the previous cycle
- plaintext  out  BLK_S  decrypted block; valid while en_o=1, held until next block's first round
- round_key_no  out  Nb  round-key index requested this cycle
- en_o  out  1  one-cycle done pulse

## Operation
- Internal regs:
  - `key_req`: key request active
  - `round_en`: `key_req` delayed 1 cycle
  - `round_no`: Nb bits
  - `state`: drives `plaintext` directly
- Idle when `key_req`=0 and `round_en`=0. `en` while busy is dropped with no effect.
- Start: on `en` while idle, `key_req`<=1 and `round_key_no`<=`rounds_total`.
- Key sequencing:
  - While `key_req`=1, `round_key_no` decrements by 1 each cycle.
  - On the cycle `key_req`=1 and `round_key_no`=0, `key_req`<=0 and `round_key_no` stays 0.
  - Key indices requested: Nr, Nr-1, …, 0. That is Nr+1 requests.
- Round datapath, evaluated on cycles with `round_en`=1, keyed on `round_no`:
  - `round_no`=0 (initial): `state` <= `ciphertext` ^ `key` (`key` = key[Nr]).
  - 0 < `round_no` < Nr: `state` <= InvMixColumns(InvSubBytes(InvShiftRows(`state`)) ^ `key`).
  - `round_no` = Nr (final): `state` <= InvSubBytes(InvShiftRows(`state`)) ^ `key` (`key` = key[0]). No InvMixColumns.
- `round_no` increments on each `round_en` cycle and wraps to 0 after the final round.
- `en_o` <= `round_en` && (`round_no` == `rounds_total`).
- Arithmetic: InvMixColumns uses GF(2^8) multiply by 0e/0b/0d/09, reduction polynomial 0x11b. Byte order within a word follows the encryption core (byte 0 = MSB).
- Inverse shift rows: row r rotates right by r bytes. Output words:
  - w0' = {b(w0,0), b(w3,1), b(w2,2), b(w1,3)}
  - w1' = {b(w1,0), b(w0,1), b(w3,2), b(w2,3)}
  - w2' = {b(w2,0), b(w1,1), b(w0,2), b(w3,3)}
  - w3' = {b(w3,0), b(w2,1), b(w1,2), b(w0,3)}

## Timing
- Reset values: `key_req`=0, `round_en`=0, `round_no`=0, `round_key_no`=0, `en_o`=0, `plaintext`=0.
- Cycle numbering, with `en` sampled at edge 0:
  - After edge 0: `key_req`=1, `round_key_no`=Nr.
  - Edges 1..Nr+1: `round_key_no` steps Nr-1…0; `key_req` falls at edge Nr+1.
  - `round_en` high after edges 1..Nr+1. Rounds execute at edges 2..Nr+2.
  - `en_o`=1 for exactly one cycle after edge Nr+2. `plaintext` is final in that same cycle.
- Latency: Nr+2 cycles from `en` sample to `en_o` (12 / 14 / 16).
- Throughput: a new `en` is accepted in the `en_o` cycle. Back-to-back blocks therefore take Nr+2 cycles each.
- Reset mid-operation: returns all control to idle the next cycle. The partial result is discarded and no `en_o` is produced.
- `en` together with `reset`: reset wins.

## Structure
- `aes.vh`: `BLK_S`, `Nb`, `WORD_S`, `BYTE_S`, `ROUND_KEY_BITS`.
- `aes_common.vh` (shared): add `get_inv_sbox`, `gm9`, `gm11`, `gm13`, `gm14`, next to the existing `get_sbox`/`gm2`/`gm3`/`aes_word`/`aes_byte`.
- One combinational sub-module, `inv_round`:
  - Inputs: state, key, last flag.
  - Output: next state.
  - Implements InvShiftRows, InvSubBytes, AddRoundKey, and conditional InvMixColumns.
- `inv_cipher` itself holds only the sequencer and `state` register.

## Test plan
The bench key store returns the FIPS-197 schedule for `round_key_no` with 1-cycle latency.
- AES-128 (key 000102…0f, Nr=10): `ciphertext` 69c4e0d86a7b0430d8cdb78070b4c55a -> `plaintext` 00112233445566778899aabbccddeeff, `en_o` 12 cycles after `en`. `round_key_no` sequence 10,9,…,0, then 0.
- AES-192 (key 000102…17, Nr=12): dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233…eeff, latency 14.
- AES-256 (key 000102…1f, Nr=14): 8ea2b7ca516745bfeafc49904b496089 -> 00112233…eeff, latency 16.
- Back-to-back: second `en` in the `en_o` cycle, then `en` pulses mid-block -> two correct results 12 cycles apart; mid-block `en` ignored; exactly two `en_o` pulses.
- Reset at cycle 5 of an AES-128 block -> next cycle `round_key_no`=0, no `en_o`. Fresh `en` afterwards decrypts correctly.
